ram_sdp_banked_ebr: RTL and testbench

//  Parametrised single-clock simple-dual-port RAM with byte enables, built from PDP16K EBR

---
 rtl/ram_sdp_banked_ebr.sv | 190 +++++++++++++++++++
 tb/tb_ram_sdp_banked_ebr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_banked_ebr.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sdp_banked_ebr
//  Brief    : Single-clock simple-dual-port RAM with byte enables, organised
//             as 512-word banks of 32-bit EBR columns (X36 mode, 9th bit of
//             each byte lane unused). Optional output register, read-valid
//             tracking, same-address write forwarding and out-of-range flag.
//  Revision : 1.0  initial release
// ============================================================================
module ram_sdp_banked_ebr #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 2880,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_W/8-1:0]   ben_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    output logic                  oor_o
);

    localparam int c_ROWS  = 512;
    localparam int c_NBANK = (DEPTH + c_ROWS - 1) / c_ROWS;
    localparam int c_NCOL  = DATA_W / 32;
    localparam int c_NBYTE = DATA_W / 8;

    // Parameter sanity checks, reported at elaboration time.
    if (DATA_W % 32 != 0) begin : g_err_width
        $error("ram_sdp_banked_ebr: DATA_W must be a multiple of 32");
    end
    if (DEPTH < 1) begin : g_err_depth_lo
        $error("ram_sdp_banked_ebr: DEPTH must be at least 1");
    end
    if (DEPTH > 16384) begin : g_err_depth_hi
        $error("ram_sdp_banked_ebr: DEPTH must not exceed 16384");
    end

    // Addresses widened to 32 bits so the range compare against DEPTH works
    // even when DEPTH is a power of two and does not fit in ADDR_W bits.
    logic [31:0]              w_wr_a32;
    logic [31:0]              w_rd_a32;
    logic [31:0]              w_wr_bank;
    logic [31:0]              w_rd_bank;
    logic [8:0]               w_wr_row;
    logic [8:0]               w_rd_row;
    logic                     w_wr_req;
    logic                     w_rd_req;
    logic                     w_wr_inr;
    logic                     w_rd_inr;
    logic                     w_wr_act;
    logic                     w_rd_act;
    logic                     w_hit;
    logic [c_NBANK-1:0]       w_wr_cs;
    logic [c_NBANK-1:0]       w_rd_cs;
    logic [c_NBANK-1:0][DATA_W-1:0] w_bank_dout;
    logic [DATA_W-1:0]        w_mux;
    logic [DATA_W-1:0]        w_s1_data;

    logic                     r_v1;
    logic                     r_oor;
    logic [c_NBANK-1:0]       r_bank_sel;
    logic                     r_hit;
    logic [c_NBYTE-1:0]       r_ben;
    logic [DATA_W-1:0]        r_wdata;

    assign w_wr_a32  = 32'(wr_addr_i);
    assign w_rd_a32  = 32'(rd_addr_i);
    assign w_wr_bank = w_wr_a32 >> 9;
    assign w_rd_bank = w_rd_a32 >> 9;
    assign w_wr_row  = w_wr_a32[8:0];
    assign w_rd_row  = w_rd_a32[8:0];

    // Strobes are ignored during reset; out-of-range writes are dropped.
    assign w_wr_req  = wr_en_i & ~rst_i;
    assign w_rd_req  = rd_en_i & ~rst_i;
    assign w_wr_inr  = (w_wr_a32 < 32'(DEPTH));
    assign w_rd_inr  = (w_rd_a32 < 32'(DEPTH));
    assign w_wr_act  = w_wr_req & w_wr_inr;
    assign w_rd_act  = w_rd_req & w_rd_inr;
    // Forwarding only applies to a write that actually lands in the array.
    assign w_hit     = (BYPASS != 0) && w_wr_act && w_rd_act && (wr_addr_i == rd_addr_i);

    // Per-bank chip selects: only the addressed bank is enabled.
    always_comb begin
        w_wr_cs = '0;
        w_rd_cs = '0;
        for (int b = 0; b < c_NBANK; b++) begin
            w_wr_cs[b] = w_wr_act && (w_wr_bank == 32'(b));
            w_rd_cs[b] = w_rd_act && (w_rd_bank == 32'(b));
        end
    end

    for (genvar b = 0; b < c_NBANK; b++) begin : g_bank
        for (genvar c = 0; c < c_NCOL; c++) begin : g_col
            logic [31:0] r_mem [0:c_ROWS-1];
            logic [31:0] r_dout;

            // EBR column: byte-masked write, registered read (read-before-write).
            always_ff @(posedge clk_i) begin
                if (w_wr_cs[b]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (ben_i[4*c+k]) begin
                            r_mem[w_wr_row][8*k +: 8] <= wr_data_i[32*c+8*k +: 8];
                        end
                    end
                end
                if (w_rd_cs[b]) begin
                    r_dout <= r_mem[w_rd_row];
                end
            end

            assign w_bank_dout[b][32*c +: 32] = r_dout;
        end
    end

    // Read-side stage 1 bookkeeping: valid, bank select, forwarding and OOR flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1       <= 1'b0;
            r_oor      <= 1'b0;
            r_bank_sel <= '0;
            r_hit      <= 1'b0;
            r_ben      <= '0;
            r_wdata    <= '0;
        end else begin
            r_v1  <= rd_en_i;
            r_oor <= (wr_en_i & ~w_wr_inr) | (rd_en_i & ~w_rd_inr);
            if (rd_en_i) begin
                r_bank_sel <= w_rd_cs;
                r_hit      <= w_hit;
                r_ben      <= ben_i;
                r_wdata    <= wr_data_i;
            end
        end
    end

    // AND-OR bank mux; an out-of-range read has no bank selected and yields 0.
    always_comb begin
        w_mux = '0;
        for (int b = 0; b < c_NBANK; b++) begin
            w_mux = w_mux | (w_bank_dout[b] & {DATA_W{r_bank_sel[b]}});
        end
    end

    // Merge forwarded write bytes over the array output on a collision.
    always_comb begin
        w_s1_data = w_mux;
        for (int k = 0; k < c_NBYTE; k++) begin
            if (r_hit && r_ben[k]) begin
                w_s1_data[8*k +: 8] = r_wdata[8*k +: 8];
            end
        end
    end

    assign oor_o = r_oor;

    if (OUT_REG != 0) begin : g_oreg
        logic              r_v2;
        logic [DATA_W-1:0] r_out;

        // Output pipeline register; data holds between valid beats.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_v2  <= 1'b0;
                r_out <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_out <= w_s1_data;
                end
            end
        end

        assign rd_valid_o = r_v2;
        assign rd_data_o  = r_out;
    end else begin : g_noreg
        assign rd_valid_o = r_v1;
        assign rd_data_o  = w_s1_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_banked_ebr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_sdp_banked_ebr
//  Brief    : Directed bench for ram_sdp_banked_ebr. Two instances share one
//             input stimulus: A (OUT_REG=0, BYPASS=1) and B (OUT_REG=1,
//             BYPASS=0), each checked against hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_sdp_banked_ebr;

    localparam int DW = 64;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    ben;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] a_data, b_data;
    logic          a_valid, b_valid, a_oor, b_oor;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_sdp_banked_ebr #(.DATA_W(64), .DEPTH(2880), .OUT_REG(0), .BYPASS(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(a_data), .rd_valid_o(a_valid), .oor_o(a_oor)
    );

    ram_sdp_banked_ebr #(.DATA_W(64), .DEPTH(2880), .OUT_REG(1), .BYPASS(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(b_data), .rd_valid_o(b_valid), .oor_o(b_oor)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; ben = be;
        step();
        wr_en = 1'b0;
    endtask

    // Single read: check A one cycle after issue, B two cycles after issue.
    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        chk({tag, "_a_valid"}, 64'(a_valid), 64'd1);
        chk({tag, "_a_data"},  a_data, exp);
        chk({tag, "_b_early"}, 64'(b_valid), 64'd0);
        step();
        chk({tag, "_b_valid"}, 64'(b_valid), 64'd1);
        chk({tag, "_b_data"},  b_data, exp);
        chk({tag, "_a_idle"},  64'(a_valid), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] addrs [4];
        logic [63:0]   exp4;
        addrs[0] = 12'd0; addrs[1] = 12'd511; addrs[2] = 12'd512; addrs[3] = 12'd2879;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; ben = '0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        step(); step();
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_a_oor",   64'(a_oor),   64'd0);
        chk("rst_b_oor",   64'(b_oor),   64'd0);
        chk("rst_a_data",  a_data, 64'd0);
        chk("rst_b_data",  b_data, 64'd0);
        rst = 1'b0;
        step();

        // Bank-edge addresses.
        for (int i = 0; i < 4; i++) wr(addrs[i], 64'hA5A5A5A5A5A5A5A5 + 64'(addrs[i]), 8'hFF);
        for (int i = 0; i < 4; i++) rd_chk("edge", addrs[i], 64'hA5A5A5A5A5A5A5A5 + 64'(addrs[i]));

        // Byte enables.
        wr(12'd5, 64'h1122334455667788, 8'hFF);
        wr(12'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        rd_chk("ben", 12'd5, 64'h11223344FFFFFFFF);
        wr(12'd6, 64'h0000000000000000, 8'hFF);
        wr(12'd6, 64'hAABBCCDDEEFF0011, 8'hA5);
        rd_chk("ben_mix", 12'd6, 64'hAA00CC0000FF0011);

        // Same-cycle collision on address 100.
        wr(12'd100, 64'h0, 8'hFF);
        wr_en = 1'b1; wr_addr = 12'd100; wr_data = 64'hDEADBEEFCAFEF00D; ben = 8'hF0;
        rd_en = 1'b1; rd_addr = 12'd100;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("coll_a_valid", 64'(a_valid), 64'd1);
        chk("coll_a_fwd",   a_data, 64'hDEADBEEF00000000);
        step();
        chk("coll_b_valid", 64'(b_valid), 64'd1);
        chk("coll_b_old",   b_data, 64'h0);
        rd_chk("coll_after", 12'd100, 64'hDEADBEEF00000000);

        // 16 back-to-back reads.
        for (int i = 0; i < 16; i++) wr(12'(1000 + i), {32'(i), 32'hC0DE0000 + 32'(i)}, 8'hFF);
        for (int i = 0; i < 18; i++) begin
            rd_en = (i < 16); rd_addr = 12'(1000 + i);
            step();
            if (i < 16) begin
                exp4 = {32'(i), 32'hC0DE0000 + 32'(i)};
                chk("burst_a_valid", 64'(a_valid), 64'd1);
                chk("burst_a_data",  a_data, exp4);
            end
            if (i == 0) begin
                chk("burst_b_lat", 64'(b_valid), 64'd0);
            end else if (i <= 16) begin
                exp4 = {32'(i - 1), 32'hC0DE0000 + 32'(i - 1)};
                chk("burst_b_valid", 64'(b_valid), 64'd1);
                chk("burst_b_data",  b_data, exp4);
            end else begin
                chk("burst_b_end", 64'(b_valid), 64'd0);
            end
        end
        rd_en = 1'b0;

        // Out-of-range write then read.
        wr(12'd2880, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        chk("oor_wr_a", 64'(a_oor), 64'd1);
        chk("oor_wr_b", 64'(b_oor), 64'd1);
        step();
        chk("oor_wr_clr", 64'(a_oor), 64'd0);
        rd_en = 1'b1; rd_addr = 12'd2880;
        step();
        rd_en = 1'b0;
        chk("oor_rd_pulse", 64'(a_oor), 64'd1);
        chk("oor_rd_a_v",   64'(a_valid), 64'd1);
        chk("oor_rd_a_d",   a_data, 64'd0);
        step();
        chk("oor_rd_clr",   64'(a_oor), 64'd0);
        chk("oor_rd_b_v",   64'(b_valid), 64'd1);
        chk("oor_rd_b_d",   b_data, 64'd0);
        rd_chk("oor_neigh", 12'd2879, 64'hA5A5A5A5A5A5A5A5 + 64'd2879);
        wr_en = 1'b1; wr_addr = 12'd3000; wr_data = '1; ben = 8'hFF;
        rd_en = 1'b1; rd_addr = 12'd3000;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("oor_both", 64'(b_oor), 64'd1);
        step();
        chk("oor_both_once", 64'(b_oor), 64'd0);
        step();

        // Reset in the cycle after a read issue.
        rd_en = 1'b1; rd_addr = 12'd5;
        step();
        rd_en = 1'b0; rst = 1'b1;
        step();
        chk("mrst_b_valid", 64'(b_valid), 64'd0);
        chk("mrst_a_data",  a_data, 64'd0);
        chk("mrst_b_data",  b_data, 64'd0);
        rst = 1'b0;
        step();
        chk("mrst_b_after", 64'(b_valid), 64'd0);
        chk("mrst_a_after", 64'(a_valid), 64'd0);
        rd_chk("mrst_keep", 12'd5, 64'h11223344FFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
